// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-MODULO counter with load, terminal count and wrap pulse.
// Defining MOD_COUNTER_CAPTURE_EN adds the cap/cap_q snapshot register.
module mod_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULO   = 16,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_CAPTURE_EN
   input  logic             cap,
   output logic [WIDTH-1:0] cap_q,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (q == MAX);
   assign at_zero = (q == ZERO);
   assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));

   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         // out-of-range loads clamp to the top of the count range
         q_next = (load_val > MAX) ? MAX : load_val;
      end else if (en) begin
         if (up) begin
            if (!at_max) begin
               q_next = q + ONE;
            end else if (!SATURATE) begin
               q_next    = ZERO;
               wrap_next = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_next = q - ONE;
            end else if (!SATURATE) begin
               q_next    = MAX;
               wrap_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= ZERO;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

`ifdef MOD_COUNTER_CAPTURE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_q <= ZERO;
      end else if (cap) begin
         cap_q <= q;
      end
   end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed checks of mod_counter in wrap and saturate builds.
// Capture checks run only when MOD_COUNTER_CAPTURE_EN is defined.
module tb_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // a: defaults, b: MODULO=10 wrap, c: MODULO=10 saturate
   logic       rst_a = 1'b1, en_a = 1'b0, up_a = 1'b0, ld_a = 1'b0;
   logic [3:0] lv_a = '0, q_a;
   logic       tc_a, wr_a;
   logic       rst_b = 1'b1, en_b = 1'b0, up_b = 1'b0, ld_b = 1'b0;
   logic [3:0] lv_b = '0, q_b;
   logic       tc_b, wr_b;
   logic       rst_c = 1'b1, en_c = 1'b0, up_c = 1'b0, ld_c = 1'b0;
   logic [3:0] lv_c = '0, q_c;
   logic       tc_c, wr_c;
`ifdef MOD_COUNTER_CAPTURE_EN
   logic       cap_a = 1'b0, cap_b = 1'b0, cap_c = 1'b0;
   logic [3:0] cq_a, cq_b, cq_c;
`endif

   mod_counter dut_a (
      .clk(clk), .reset(rst_a), .en(en_a), .up(up_a),
      .load(ld_a), .load_val(lv_a),
`ifdef MOD_COUNTER_CAPTURE_EN
      .cap(cap_a), .cap_q(cq_a),
`endif
      .q(q_a), .tc(tc_a), .wrap(wr_a)
   );

   mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) dut_b (
      .clk(clk), .reset(rst_b), .en(en_b), .up(up_b),
      .load(ld_b), .load_val(lv_b),
`ifdef MOD_COUNTER_CAPTURE_EN
      .cap(cap_b), .cap_q(cq_b),
`endif
      .q(q_b), .tc(tc_b), .wrap(wr_b)
   );

   mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) dut_c (
      .clk(clk), .reset(rst_c), .en(en_c), .up(up_c),
      .load(ld_c), .load_val(lv_c),
`ifdef MOD_COUNTER_CAPTURE_EN
      .cap(cap_c), .cap_q(cq_c),
`endif
      .q(q_c), .tc(tc_c), .wrap(wr_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_q_a", q_a, 0);
      chk("rst_w_a", wr_a, 0);
      chk("rst_q_b", q_b, 0);
      chk("rst_q_c", q_c, 0);
      rst_a = 0; rst_b = 0; rst_c = 0;

      // default build: 20 up edges from reset
      en_a = 1; up_a = 1;
      #1 chk("a_tc0", tc_a, 0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("a_up_q%0d", i), q_a, i % 16);
         chk($sformatf("a_up_w%0d", i), wr_a, (i == 16) ? 1 : 0);
         chk($sformatf("a_up_tc%0d", i), tc_a, (i % 16 == 15) ? 1 : 0);
      end
      up_a = 0;
      #1 chk("a_dir_tc", tc_a, 0);
      tick();
      chk("a_dir_q", q_a, 3);

      ld_a = 1; lv_a = 4'd15;
      #1 chk("a_ld_tc", tc_a, 0);
      tick();
      chk("a_ld_q", q_a, 15);
      chk("a_ld_w", wr_a, 0);
      ld_a = 0; up_a = 1;
      #1 chk("a_max_tc", tc_a, 1);
      tick();
      chk("a_nat_q", q_a, 0);
      chk("a_nat_w", wr_a, 1);
      up_a = 0;
      #1 chk("a_zero_tc", tc_a, 1);
      tick();
      chk("a_dn_q", q_a, 15);
      chk("a_dn_w", wr_a, 1);
      en_a = 0;
      #1 chk("a_hold_tc", tc_a, 0);
      tick();
      chk("a_hold_q", q_a, 15);
      chk("a_hold_w", wr_a, 0);

      // async reset while wrap is high
      en_a = 1; up_a = 1;
      tick();
      chk("a_pre_w", wr_a, 1);
      #2 rst_a = 1;
      #1 chk("a_ar_q", q_a, 0);
      chk("a_ar_w", wr_a, 0);
      tick();
      chk("a_arh_q", q_a, 0);
      rst_a = 0;
      tick();
      chk("a_rel_q", q_a, 1);
      chk("a_rel_w", wr_a, 0);

      // async reset between edges at q=6
      ld_a = 1; lv_a = 4'd6;
      tick();
      chk("a_six_q", q_a, 6);
      ld_a = 0;
      #2 rst_a = 1;
      #1 chk("a_ar6_q", q_a, 0);
      chk("a_ar6_w", wr_a, 0);
      #1 rst_a = 0;
      tick();
      chk("a_res_q", q_a, 1);

`ifdef MOD_COUNTER_CAPTURE_EN
      ld_a = 1; lv_a = 4'd4; en_a = 0;
      tick();
      chk("cap_pre_q", q_a, 4);
      chk("cap_init", cq_a, 0);
      ld_a = 0; en_a = 1; up_a = 1; cap_a = 1;
      tick();
      chk("cap_q5", q_a, 5);
      chk("cap_val", cq_a, 4);
      cap_a = 0;
      tick();
      chk("cap_hold1", cq_a, 4);
      tick();
      chk("cap_hold2", cq_a, 4);
      chk("cap_q7", q_a, 7);
`endif
      en_a = 0;

      // MODULO=10 down from 0
      en_b = 1; up_b = 0;
      #1 chk("b_tc0", tc_b, 1);
      for (int i = 1; i <= 11; i++) begin
         tick();
         chk($sformatf("b_dn_q%0d", i), q_b, (10 - (i % 10)) % 10);
         chk($sformatf("b_dn_w%0d", i), wr_b, (i == 1 || i == 11) ? 1 : 0);
      end
      ld_b = 1; lv_b = 4'd13; up_b = 1;
      #1 chk("b_ld_tc", tc_b, 0);
      tick();
      chk("b_clamp_q", q_b, 9);
      chk("b_clamp_w", wr_b, 0);
      lv_b = 4'd2;
      tick();
      chk("b_ld2_q", q_b, 2);
      lv_b = 4'd10;
      tick();
      chk("b_ld10_q", q_b, 9);
      chk("b_ld10_w", wr_b, 0);
      ld_b = 0;
      #1 chk("b_max_tc", tc_b, 1);
      tick();
      chk("b_wrap_q", q_b, 0);
      chk("b_wrap_w", wr_b, 1);
      en_b = 0;
      tick();
      chk("b_hold_q", q_b, 0);
      chk("b_hold_w", wr_b, 0);

      // MODULO=10 saturate
      ld_c = 1; lv_c = 4'd7;
      tick();
      chk("c_ld_q", q_c, 7);
      ld_c = 0; en_c = 1; up_c = 1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("c_up_q%0d", i), q_c, (i == 1) ? 8 : 9);
         chk($sformatf("c_up_w%0d", i), wr_c, 0);
         chk($sformatf("c_up_tc%0d", i), tc_c, (i == 1) ? 0 : 1);
      end
      ld_c = 1; lv_c = 4'd0; up_c = 0;
      tick();
      chk("c_ld0_q", q_c, 0);
      ld_c = 0;
      #1 chk("c_zero_tc", tc_c, 1);
      tick();
      chk("c_sat0_q", q_c, 0);
      chk("c_sat0_w", wr_c, 0);
      up_c = 1;
      tick();
      chk("c_up1_q", q_c, 1);
      en_c = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
